// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and transmitter-side byte bus of the UART TX
//            arbiter, plus the grant status outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 grant_active;
  logic [GW-1:0]        grant_id;

  // Arbiter side
  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_active, grant_id
  );

  // Requesters / transmitter / observer side
  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_active, grant_id
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter byte port among
//            NUM_REQ requesters through a single registered holding byte.
//            An idle-timeout revokes the grant of a stalled owner.
//            Optional macro UART_ARB_PACKET_LOCK_EN: keep the grant until a
//            byte flagged last (otherwise every byte releases the grant).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int            CW         = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] C_LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [GW-1:0] rr_ptr_q,    rr_ptr_d;
  logic [GW-1:0] grant_id_q,  grant_id_d;
  logic [CW-1:0] idle_cnt_q,  idle_cnt_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    hold_data_q, hold_data_d;

  int            w_cand;
  logic [GW-1:0] w_cand_idx;
  logic [GW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic [GW-1:0] w_next_ptr;
  logic          w_owner_valid;
  logic          w_owner_last;
  logic [7:0]    w_owner_data;
  logic          w_accept;
  logic          w_release_on_accept;

  // Round-robin search: first valid index at or above rr_ptr, wrapping at NUM_REQ
  always_comb begin
    w_cand       = 0;
    w_cand_idx   = '0;
    w_pick_idx   = rr_ptr_q;
    w_pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = int'(rr_ptr_q) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      w_cand_idx = GW'(w_cand);
      if (!w_pick_found && bus.req_valid[w_cand_idx]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand_idx;
      end
    end
  end

  // Owner-side decode; the pointer wrap is explicit so non-power-of-two counts work
  always_comb begin
    w_owner_valid = bus.req_valid[grant_id_q];
    w_owner_last  = bus.req_last[grant_id_q];
    w_owner_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];
    w_next_ptr    = (grant_id_q == C_LAST_IDX) ? '0 : grant_id_q + GW'(1);
    w_accept      = (state_q == S_OWN) && !hold_full_q && w_owner_valid;
`ifdef UART_ARB_PACKET_LOCK_EN
    w_release_on_accept = w_owner_last;
`else
    w_release_on_accept = 1'b1;
`endif
  end

  // Next-state logic: arbitration, byte accept, last/timeout release, hold drain
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    idle_cnt_d  = idle_cnt_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;

    // Drain can never coincide with accept, which needs an empty hold
    if (hold_full_q && bus.tx_ready) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_pick_found) begin
          grant_id_d = w_pick_idx;
          idle_cnt_d = '0;
          state_d    = S_OWN;
        end
      end
      S_OWN: begin
        if (w_accept) begin
          hold_data_d = w_owner_data;
          hold_full_d = 1'b1;
          idle_cnt_d  = '0;
          if (w_release_on_accept) begin
            state_d  = S_IDLE;
            rr_ptr_d = w_next_ptr;
          end
        end else if (!hold_full_q && !w_owner_valid) begin
          if (idle_cnt_q == C_CNT_LAST) begin
            idle_cnt_d = '0;
            state_d    = S_IDLE;
            rr_ptr_d   = w_next_ptr;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      idle_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      idle_cnt_q  <= idle_cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Ready is offered only to the owner and only while the hold byte is free
  always_comb begin
    bus.req_ready = '0;
    if ((state_q == S_OWN) && !hold_full_q) begin
      bus.req_ready[grant_id_q] = 1'b1;
    end
  end

  assign bus.tx_valid     = hold_full_q;
  assign bus.tx_data      = hold_data_q;
  assign bus.grant_active = (state_q == S_OWN);
  assign bus.grant_id     = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter (NUM_REQ=3,
//            LOCK_TIMEOUT=8). Directed latency/timeout/reset steps plus
//            queue-driven traffic compared to a transaction-order model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N   = 3;
  localparam int LT  = 8;
  localparam int GWB = 2;
  localparam int QD  = 64;
`ifdef UART_ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // requester byte queues
  logic [7:0] md    [N][QD];
  bit         ml    [N][QD];
  int         mhead [N];
  int         mtail [N];
  // expected transmit order
  logic [7:0] exp_d [256];
  int         exp_s [256];
  int         exp_n, acc_idx, tx_idx, since_acc, mode;
  int         ser;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, bit v, logic [7:0] d, bit l);
    bus.req_valid[i]         = v;
    bus.req_data[8*i +: 8]   = d;
    bus.req_last[i]          = l;
  endtask

  task automatic push(int i, logic [7:0] d, bit l);
    md[i][mtail[i]] = d;
    ml[i][mtail[i]] = l;
    mtail[i]++;
  endtask

  // Order model: round robin over non-empty queues; a win takes a whole
  // packet when locked, a single byte otherwise.
  function automatic void build_model();
    int h[N];
    int ptr, remaining, w;
    bit done;
    exp_n = 0; ptr = 0; remaining = 0;
    for (int i = 0; i < N; i++) begin
      h[i] = mhead[i];
      remaining += mtail[i] - mhead[i];
    end
    while (remaining > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && h[(ptr + k) % N] < mtail[(ptr + k) % N]) w = (ptr + k) % N;
      end
      done = 1'b0;
      while (!done) begin
        exp_d[exp_n] = md[w][h[w]];
        exp_s[exp_n] = w;
        done = !LOCK || ml[w][h[w]];
        exp_n++; h[w]++; remaining--;
        if (h[w] >= mtail[w]) done = 1'b1;
      end
      ptr = (w + 1) % N;
    end
  endfunction

  task automatic drive_from_queues();
    for (int i = 0; i < N; i++) begin
      if (mhead[i] < mtail[i]) set_req(i, 1'b1, md[i][mhead[i]], ml[i][mhead[i]]);
      else                     set_req(i, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic tick();
    logic [N-1:0]   acc;
    logic           drn;
    logic [7:0]     txd;
    logic [GWB-1:0] gid;
    acc = bus.req_ready & bus.req_valid;
    drn = bus.tx_valid & bus.tx_ready;
    txd = bus.tx_data;
    gid = bus.grant_id;
    @(posedge clk); #1;
    if (acc != '0) begin
      since_acc = 0;
      chk("acc_onehot", 32'($onehot(acc)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if (acc_idx < exp_n) begin
            chk("acc_src", i, exp_s[acc_idx]);
            chk("acc_gid", 32'(gid), i);
            chk("grant_after_acc", 32'(bus.grant_active), 32'(LOCK && !ml[i][mhead[i]]));
          end else begin
            chk("acc_extra", acc_idx, exp_n - 1);
          end
          acc_idx++;
          mhead[i]++;
        end
      end
    end else begin
      since_acc++;
    end
    if (drn) begin
      if (tx_idx < exp_n) chk("tx_order", 32'(txd), 32'(exp_d[tx_idx]));
      else                chk("tx_extra", tx_idx, exp_n - 1);
      tx_idx++;
    end
    drive_from_queues();
    bus.tx_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : (since_acc >= 10);
  endtask

  task automatic run_engine(int m, int budget);
    int c;
    mode = m; acc_idx = 0; tx_idx = 0; since_acc = 100;
    build_model();
    drive_from_queues();
    bus.tx_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    c = 0;
    while (tx_idx < exp_n && c < budget) begin
      tick();
      c++;
    end
    chk("tx_count",  tx_idx,  exp_n);
    chk("acc_count", acc_idx, exp_n);
    chk("end_grant", 32'(bus.grant_active), 32'd0);
    chk("end_txv",   32'(bus.tx_valid),     32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      mhead[i] = 0; mtail[i] = 0;
      set_req(i, 1'b0, 8'h00, 1'b0);
    end
    bus.tx_ready = 1'b0;
    #1;
    chk("rst_txv",   32'(bus.tx_valid),     32'd0);
    chk("rst_txd",   32'(bus.tx_data),      32'd0);
    chk("rst_ready", 32'(bus.req_ready),    32'd0);
    chk("rst_grant", 32'(bus.grant_active), 32'd0);
    chk("rst_gid",   32'(bus.grant_id),     32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt, fall, npk, len;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b0;
    ser = 0;
    #2;

    // ---- first-byte latency from IDLE
    do_reset();
    set_req(0, 1'b1, 8'h5A, 1'b1);
    @(posedge clk); #1;
    chk("lat_c1_grant", 32'(bus.grant_active), 32'd1);
    chk("lat_c1_ready", 32'(bus.req_ready),    32'b001);
    chk("lat_c1_gid",   32'(bus.grant_id),     32'd0);
    chk("lat_c1_txv",   32'(bus.tx_valid),     32'd0);
    @(posedge clk); #1;
    chk("lat_c2_txv",   32'(bus.tx_valid),     32'd1);
    chk("lat_c2_txd",   32'(bus.tx_data),      32'h5A);
    chk("lat_c2_ready", 32'(bus.req_ready),    32'd0);
    chk("lat_c2_grant", 32'(bus.grant_active), 32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("lat_c3_txv",   32'(bus.tx_valid),     32'd0);

    // ---- single-requester burst, slow transmitter
    do_reset();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    run_engine(1, 300);

    // ---- packet lock versus byte interleave
    do_reset();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    run_engine(0, 300);

    // ---- fairness: all valid, single-byte packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'(8'h80 + 16 * i + r), 1'b1);
    run_engine(0, 300);

    // ---- owner stalls after a byte without last
    do_reset();
    set_req(0, 1'b1, 8'h55, 1'b0);
    @(posedge clk); #1;
    chk("to_c1_grant", 32'(bus.grant_active), 32'd1);
    @(posedge clk); #1;
    chk("to_c2_txv", 32'(bus.tx_valid), 32'd1);
    chk("to_c2_txd", 32'(bus.tx_data),  32'h55);
    set_req(0, 1'b0, 8'h00, 1'b0);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 8'h66, 1'b1);
    chk("to_c3_grant", 32'(bus.grant_active), 32'(LOCK));
    chk("to_c3_txv",   32'(bus.tx_valid),     32'd0);
    cnt  = 1;
    fall = bus.grant_active ? 0 : 1;
    while (!(bus.grant_active && bus.grant_id == 2'd1) && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
      if (fall == 0 && !bus.grant_active) fall = cnt;
    end
    chk("to_fall_cycle",    fall, LOCK ? 9 : 1);
    chk("to_regrant_cycle", cnt,  LOCK ? 10 : 2);
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h00, 1'b0);
    chk("to_next_txv", 32'(bus.tx_valid), 32'd1);
    chk("to_next_txd", 32'(bus.tx_data),  32'h66);

    // ---- owner drops valid before any byte, then pointer wraps 2 -> 0
    do_reset();
    bus.tx_ready = 1'b1;
    set_req(2, 1'b1, 8'h77, 1'b1);
    @(posedge clk); #1;
    chk("stall_grant", 32'(bus.grant_active), 32'd1);
    chk("stall_gid",   32'(bus.grant_id),     32'd2);
    chk("stall_ready", 32'(bus.req_ready),    32'b100);
    set_req(2, 1'b0, 8'h00, 1'b0);
    cnt = 1;
    while (bus.grant_active && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("stall_fall_cycle", cnt, 9);
    chk("stall_no_byte", 32'(bus.tx_valid), 32'd0);
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(1, 1'b1, 8'h02, 1'b1);
    @(posedge clk); #1;
    chk("wrap_grant", 32'(bus.grant_active), 32'd1);
    chk("wrap_gid",   32'(bus.grant_id),     32'd0);

    // ---- asynchronous reset while owning with a full hold byte
    do_reset();
    set_req(0, 1'b1, 8'h31, 1'b0);
    set_req(1, 1'b1, 8'h32, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_pre_grant", 32'(bus.grant_active), 32'd1);
    chk("mid_pre_txv",   32'(bus.tx_valid),     32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_txv",   32'(bus.tx_valid),     32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready),    32'd0);
    chk("mid_rst_grant", 32'(bus.grant_active), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_after_grant", 32'(bus.grant_active), 32'd1);
    chk("mid_after_gid",   32'(bus.grant_id),     32'd0);

    // ---- randomized packet traffic with random transmitter ready
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            push(i, {2'(i), 6'(ser)}, b == len - 1);
            ser++;
          end
        end
      end
      run_engine(0, 3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
